// File: rtl/axi_line_port_pkg.sv
// Shared types and constants for the cache-to-DDR line port.
package axi_line_port_pkg;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned STRB_W = LINE_W / 8;

  localparam logic [2:0] AXI_SIZE_LINE  = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_WB_FILL = 2'b10
  } line_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrB,
    StRdA,
    StRdD,
    StDone
  } line_state_e;

endpackage

// File: rtl/axi_line_port_if.sv
// Single-beat AXI4 bus between the line port (master) and the DDR controller (slave).
interface axi_line_port_if;
  import axi_line_port_pkg::*;

  logic              awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awuser;
  logic              awvalid;
  logic              awready;

  logic [LINE_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic              bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic              arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              aruser;
  logic              arvalid;
  logic              arready;

  logic              rid;
  logic [LINE_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_line_port.sv
// Turns one cache line request (fill, write-back, or write-back + fill) into single-beat
// AXI4 transactions; one request outstanding at a time.
module axi_line_port
  import axi_line_port_pkg::*;
#(
  parameter logic AXI_ID = 1'b0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              resp_err,
  axi_line_port_if.master   m_axi
);

  line_state_e       state_q, state_d;
  logic [ADDR_W-1:4] addr_q, addr_d;
  logic [ADDR_W-1:4] wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              fill_q, fill_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wb_addr_d = wb_addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fill_d    = fill_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d    = req_addr[ADDR_W-1:4];
          wb_addr_d = req_wb_addr[ADDR_W-1:4];
          wdata_d   = req_wdata;
          fill_d    = (req_op == OP_WB_FILL);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          // Reserved opcode falls through to a plain read.
          state_d   = (req_op == OP_WRITE || req_op == OP_WB_FILL) ? StWr : StRdA;
        end
      end
      StWr: begin
        if (m_axi.awready) aw_done_d = 1'b1;
        if (m_axi.wready)  w_done_d  = 1'b1;
        if ((aw_done_q || m_axi.awready) && (w_done_q || m_axi.wready)) state_d = StWrB;
      end
      StWrB: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = fill_q ? StRdA : StDone;
        end
      end
      StRdA: begin
        if (m_axi.arready) state_d = StRdD;
      end
      StRdD: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          if (m_axi.rresp != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wb_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      fill_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wb_addr_q <= wb_addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      fill_q    <= fill_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  // Every VALID/READY is decoded from registered state only.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign m_axi.awvalid = (state_q == StWr) && !aw_done_q;
  assign m_axi.wvalid  = (state_q == StWr) && !w_done_q;
  assign m_axi.bready  = (state_q == StWrB);
  assign m_axi.arvalid = (state_q == StRdA);
  assign m_axi.rready  = (state_q == StRdD);

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = {wb_addr_q, 4'h0};
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = AXI_SIZE_LINE;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXI_CACHE_MOD;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'h0;
  assign m_axi.awuser  = 1'b0;

  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = 1'b1;

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = {addr_q, 4'h0};
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = AXI_SIZE_LINE;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AXI_CACHE_MOD;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'h0;
  assign m_axi.aruser  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{m_axi.bid, m_axi.rid, m_axi.rlast, req_addr[3:0], req_wb_addr[3:0]};

endmodule

// File: tb/tb_axi_line_port.sv
// Directed bench for axi_line_port: read, write with stalled AW, write-back + fill,
// error reporting, mid-transaction reset and back-to-back requests.
module tb_axi_line_port;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [26:0]  req_addr;
  logic [26:0]  req_wb_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         resp_err;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int base;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_W  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PAT_F  = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
  localparam logic [127:0] PAT_G  = 128'h5A5A_0F0F_1234_5678_9ABC_DEF0_A1B2_C3D4;

  axi_line_port_if axi ();

  axi_line_port #(
    .AXI_ID(1'b0)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wb_addr(req_wb_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .m_axi      (axi.master)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) if (resp_valid) resp_cnt <= resp_cnt + 1;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_awvalid"}, 128'(axi.awvalid), 128'd0);
    chk({tag, "_wvalid"},  128'(axi.wvalid),  128'd0);
    chk({tag, "_bready"},  128'(axi.bready),  128'd0);
    chk({tag, "_arvalid"}, 128'(axi.arvalid), 128'd0);
    chk({tag, "_rready"},  128'(axi.rready),  128'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [26:0] a, input logic [26:0] wb,
                       input logic [127:0] wd);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr    = a;
    req_wb_addr = wb;
    req_wdata   = wd;
    tick();
    req_valid   = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wb_addr = '0; req_wdata = '0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b1; axi.rid = 1'b0;
    tick(); tick();
    ARESET = 1'b0;

    // Reset state
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    chk("rst_resp_err", 128'(resp_err), 128'd0);
    chk("rst_resp_rdata", resp_rdata, 128'd0);
    chk_idle_bus("rst");

    // 1: plain read, slave ready immediately
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = PAT_A5; axi.rresp = 2'b00;
    base = resp_cnt;
    issue(2'b00, 27'h0000123, 27'h0, '0);
    chk("t1_arvalid", 128'(axi.arvalid), 128'd1);
    chk("t1_araddr", 128'(axi.araddr), 128'h0000120);
    chk("t1_arsize", 128'(axi.arsize), 128'h4);
    chk("t1_arburst", 128'(axi.arburst), 128'h1);
    chk("t1_arlen", 128'(axi.arlen), 128'h0);
    chk("t1_awvalid", 128'(axi.awvalid), 128'd0);
    chk("t1_req_ready_busy", 128'(req_ready), 128'd0);
    tick();
    chk("t1_rready", 128'(axi.rready), 128'd1);
    chk("t1_arvalid_drop", 128'(axi.arvalid), 128'd0);
    chk("t1_resp_early", 128'(resp_valid), 128'd0);
    tick();
    chk("t1_resp_valid", 128'(resp_valid), 128'd1);
    chk("t1_resp_rdata", resp_rdata, PAT_A5);
    chk("t1_resp_err", 128'(resp_err), 128'd0);
    tick();
    chk("t1_resp_pulse", 128'(resp_valid), 128'd0);
    chk("t1_req_ready", 128'(req_ready), 128'd1);
    chk("t1_resp_count", 128'(resp_cnt - base), 128'd1);
    axi.arready = 1'b0; axi.rvalid = 1'b0;

    // 2: write, AWREADY delayed, WREADY immediate
    axi.wready = 1'b1;
    base = resp_cnt;
    issue(2'b01, 27'h0, 27'h0000040, PAT_W);
    chk("t2_awvalid_c1", 128'(axi.awvalid), 128'd1);
    chk("t2_wvalid_c1", 128'(axi.wvalid), 128'd1);
    chk("t2_wdata", axi.wdata, PAT_W);
    chk("t2_wstrb", 128'(axi.wstrb), 128'hFFFF);
    chk("t2_wlast", 128'(axi.wlast), 128'd1);
    chk("t2_awcache", 128'(axi.awcache), 128'h3);
    chk("t2_awaddr_c1", 128'(axi.awaddr), 128'h40);
    tick();
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("t2_awvalid_c%0d", c), 128'(axi.awvalid), 128'd1);
      chk($sformatf("t2_awaddr_c%0d", c), 128'(axi.awaddr), 128'h40);
      chk($sformatf("t2_wvalid_c%0d", c), 128'(axi.wvalid), 128'd0);
      chk($sformatf("t2_bready_c%0d", c), 128'(axi.bready), 128'd0);
      if (c == 4) axi.awready = 1'b1;
      tick();
    end
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk("t2_awvalid_drop", 128'(axi.awvalid), 128'd0);
    chk("t2_bready", 128'(axi.bready), 128'd1);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    tick();
    axi.bvalid = 1'b0;
    chk("t2_resp_valid", 128'(resp_valid), 128'd1);
    chk("t2_resp_err", 128'(resp_err), 128'd0);
    chk("t2_bready_drop", 128'(axi.bready), 128'd0);
    tick();
    chk("t2_resp_count", 128'(resp_cnt - base), 128'd1);

    // 3: write-back + fill, BVALID delayed two cycles
    axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
    axi.rvalid = 1'b1; axi.rdata = PAT_F; axi.rresp = 2'b00;
    base = resp_cnt;
    issue(2'b10, 27'h0000200, 27'h0000100, PAT_G);
    chk("t3_awaddr", 128'(axi.awaddr), 128'h100);
    chk("t3_wdata", axi.wdata, PAT_G);
    chk("t3_arvalid_c1", 128'(axi.arvalid), 128'd0);
    tick();
    chk("t3_bready_c2", 128'(axi.bready), 128'd1);
    chk("t3_arvalid_c2", 128'(axi.arvalid), 128'd0);
    tick();
    chk("t3_arvalid_c3", 128'(axi.arvalid), 128'd0);
    axi.bvalid = 1'b1;
    tick();
    axi.bvalid = 1'b0;
    chk("t3_arvalid_c4", 128'(axi.arvalid), 128'd1);
    chk("t3_araddr", 128'(axi.araddr), 128'h200);
    chk("t3_bready_c4", 128'(axi.bready), 128'd0);
    tick();
    chk("t3_rready", 128'(axi.rready), 128'd1);
    chk("t3_resp_early", 128'(resp_valid), 128'd0);
    tick();
    chk("t3_resp_valid", 128'(resp_valid), 128'd1);
    chk("t3_resp_rdata", resp_rdata, PAT_F);
    chk("t3_resp_err", 128'(resp_err), 128'd0);
    tick();
    chk("t3_resp_count", 128'(resp_cnt - base), 128'd1);

    // 4: SLVERR on write-back with all slave handshakes immediate (minimum 5-cycle latency)
    axi.bvalid = 1'b1; axi.bresp = 2'b10; axi.rdata = PAT_A5;
    issue(2'b10, 27'h0000300, 27'h0000310, PAT_W);
    tick(); tick(); tick();
    chk("t4_resp_c4", 128'(resp_valid), 128'd0);
    tick();
    chk("t4_resp_valid", 128'(resp_valid), 128'd1);
    chk("t4_resp_err", 128'(resp_err), 128'd1);
    chk("t4_resp_rdata", resp_rdata, PAT_A5);
    tick();
    axi.bresp = 2'b00; axi.rdata = PAT_G;
    issue(2'b00, 27'h0000400, 27'h0, '0);
    tick();
    tick();
    chk("t4b_resp_valid", 128'(resp_valid), 128'd1);
    chk("t4b_resp_err", 128'(resp_err), 128'd0);
    chk("t4b_resp_rdata", resp_rdata, PAT_G);
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;

    // 5: reset while waiting for read data
    axi.arready = 1'b1; axi.rvalid = 1'b0;
    base = resp_cnt;
    issue(2'b00, 27'h0000500, 27'h0, '0);
    tick();
    chk("t5_rready", 128'(axi.rready), 128'd1);
    ARESET = 1'b1;
    tick();
    chk_idle_bus("t5_rst");
    chk("t5_resp_valid_rst", 128'(resp_valid), 128'd0);
    ARESET = 1'b0;
    chk("t5_req_ready", 128'(req_ready), 128'd1);
    tick(); tick();
    chk("t5_no_resp", 128'(resp_cnt - base), 128'd0);
    axi.rvalid = 1'b1; axi.rdata = PAT_F;
    issue(2'b11, 27'h000060F, 27'h0, '0);
    chk("t5_reserved_araddr", 128'(axi.araddr), 128'h600);
    chk("t5_reserved_awvalid", 128'(axi.awvalid), 128'd0);
    tick(); tick();
    chk("t5_new_resp", 128'(resp_valid), 128'd1);
    chk("t5_new_rdata", resp_rdata, PAT_F);
    tick();

    // 6: back-to-back reads with req_valid held high
    req_valid = 1'b1; req_op = 2'b00; req_addr = 27'h0000700;
    tick();
    chk("t6_ready_c1", 128'(req_ready), 128'd0);
    tick();
    chk("t6_ready_c2", 128'(req_ready), 128'd0);
    tick();
    chk("t6_resp_c3", 128'(resp_valid), 128'd1);
    chk("t6_ready_c3", 128'(req_ready), 128'd0);
    tick();
    chk("t6_ready_c4", 128'(req_ready), 128'd1);
    chk("t6_arvalid_c4", 128'(axi.arvalid), 128'd0);
    req_addr = 27'h0000810;
    tick();
    req_valid = 1'b0;
    chk("t6_arvalid_c5", 128'(axi.arvalid), 128'd1);
    chk("t6_araddr_c5", 128'(axi.araddr), 128'h810);
    tick(); tick();
    chk("t6_resp_second", 128'(resp_valid), 128'd1);
    tick();
    chk("t6_idle", 128'(req_ready), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
